// File: rtl/out_port_rr_alloc_pkg.sv
`default_nettype none
// ============================================================================
// out_port_rr_alloc_pkg : shared types and helpers for the output-port allocator
// Revision: 1.0
// ============================================================================
package out_port_rr_alloc_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int OH_MAX_W = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Encodes a one-hot (or zero) vector; zero input yields index 0.
  function automatic logic [OH_MAX_W-1:0] onehot_to_bin(input logic [OH_MAX_W-1:0] oh);
    logic [OH_MAX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) bin = bin | OH_MAX_W'(i);
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_rr_alloc_fpa.sv
`default_nettype none
// ============================================================================
// FPA_X_IN : fixed-priority first-one detector, lowest index wins
// Revision: 1.0
// ============================================================================
module FPA_X_IN #(
  parameter int IO_SIZE = 5
) (
  input  logic [IO_SIZE-1:0] req,
  output logic [IO_SIZE-1:0] gnt
);

  logic [IO_SIZE-1:0] lower_any;

  assign lower_any[0] = 1'b0;

  // lower_any[i] is set when any bit below i requests (prefix OR).
  for (genvar i = 1; i < IO_SIZE; i++) begin : g_prefix
    assign lower_any[i] = lower_any[i-1] | req[i-1];
  end

  assign gnt = req & ~lower_any;

endmodule
`default_nettype wire

// File: rtl/out_port_rr_alloc.sv
`default_nettype none
// ============================================================================
// out_port_rr_alloc : round-robin output-port allocator with packet locking
// Revision: 1.0
// ============================================================================
module out_port_rr_alloc
  import out_port_rr_alloc_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int ID_W      = clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] tail_i,
  input  logic                 avail_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [ID_W-1:0]      grant_id_o,
  output logic                 locked_o
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [NUM_PORTS-1:0] mask_hi, masked, fpa_in, candidate, owner_oh, grant;
  logic [ID_W-1:0]     grant_id;
  logic                fire, tail_w;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_mask
    assign mask_hi[i] = (ID_W'(i) > ptr);
  end

  assign masked = req_i & mask_hi;
  assign fpa_in = (|masked) ? masked : req_i;

  FPA_X_IN #(
    .IO_SIZE (NUM_PORTS)
  ) u_fpa (
    .req (fpa_in),
    .gnt (candidate)
  );

  assign owner_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;

  always_comb begin
    grant = '0;
    if (rst_n) begin
      if (state == LOCKED) begin
        if (avail_i && |(req_i & owner_oh)) grant = owner_oh;
      end else if (avail_i) begin
        grant = candidate;
      end
    end
  end

  assign grant_id   = ID_W'(onehot_to_bin(OH_MAX_W'(grant)));
  assign fire       = |grant;
  assign tail_w     = |(tail_i & grant);
  assign grant_o    = grant;
  assign grant_id_o = grant_id;
  assign locked_o   = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    if (fire) begin
      if (state == LOCKED) begin
        if (tail_w) begin
          state_nxt = IDLE;
          ptr_nxt   = owner;
        end
      end else if (tail_w) begin
        ptr_nxt = grant_id;
      end else begin
        state_nxt = LOCKED;
        owner_nxt = grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= ID_W'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_port_rr_alloc.sv
`default_nettype none
// ============================================================================
// tb_out_port_rr_alloc : directed plus randomized bench against a reference model
// Revision: 1.0
// ============================================================================
module tb_out_port_rr_alloc;

  localparam int N = 5;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] tail;
  logic         avail;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic         locked;

  int n_cmp;
  int n_err;

  // Reference model: packet owner, and the last port that finished being served.
  bit m_locked;
  int m_owner;
  int m_last;

  logic [N-1:0] last_grant;

  out_port_rr_alloc #(
    .NUM_PORTS (N),
    .ID_W      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .tail_i     (tail),
    .avail_i    (avail),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .locked_o   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
  endtask

  // Winning port index for this cycle, or -1 for no grant.
  function automatic int model_winner(input logic [N-1:0] r, input logic a);
    int w;
    w = -1;
    if (a) begin
      if (m_locked) begin
        if (r[m_owner]) w = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && r[(m_last + k) % N]) w = (m_last + k) % N;
        end
      end
    end
    return w;
  endfunction

  task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] t, input logic a);
    int           w;
    logic [N-1:0] eg;
    req   = r;
    tail  = t;
    avail = a;
    #1;
    w  = model_winner(r, a);
    eg = (w >= 0) ? N'(1 << w) : '0;
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("grant_id", 32'(grant_id), (w >= 0) ? 32'(w) : 32'd0);
    check_eq("locked", 32'(locked), 32'(m_locked));
    last_grant = grant;
    @(posedge clk);
    if (w >= 0) begin
      if (!m_locked) begin
        if (t[w]) m_last = w;
        else begin
          m_locked = 1'b1;
          m_owner  = w;
        end
      end else if (t[m_owner]) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] rr_exp [4];
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst_n = 1'b0;
    req   = '1;
    tail  = '1;
    avail = 1'b1;
    #12;
    check_eq("reset_grant", 32'(grant), 32'd0);
    check_eq("reset_grant_id", 32'(grant_id), 32'd0);
    check_eq("reset_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order over ports 1, 2, 4
    rr_exp[0] = 5'b00010;
    rr_exp[1] = 5'b00100;
    rr_exp[2] = 5'b10000;
    rr_exp[3] = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(5'b10110, 5'b11111, 1'b1);
      check_eq("rr_seq", 32'(last_grant), 32'(rr_exp[i]));
    end

    // Packet lock on port 3
    drive_cycle(5'b01000, 5'b00000, 1'b1);
    check_eq("lock_head", 32'(last_grant), 32'(5'b01000));
    for (int i = 0; i < 3; i++) drive_cycle(5'b11001, 5'b00000, 1'b1);
    drive_cycle(5'b11001, 5'b01000, 1'b1);
    check_eq("lock_tail", 32'(last_grant), 32'(5'b01000));
    drive_cycle(5'b11001, 5'b11111, 1'b1);
    check_eq("after_tail", 32'(last_grant), 32'(5'b10000));

    // Backpressure
    for (int i = 0; i < 3; i++) drive_cycle(5'b11111, 5'b11111, 1'b0);
    drive_cycle(5'b11111, 5'b11111, 1'b1);
    check_eq("bp_release", 32'(last_grant), 32'(5'b00001));

    // Owner bubble on port 2
    drive_cycle(5'b00100, 5'b00000, 1'b1);
    for (int i = 0; i < 2; i++) drive_cycle(5'b11011, 5'b11111, 1'b1);
    drive_cycle(5'b11111, 5'b11111, 1'b1);
    check_eq("bubble_return", 32'(last_grant), 32'(5'b00100));

    // Reset mid-packet with port 1 locked
    drive_cycle(5'b00010, 5'b00000, 1'b1);
    req  = 5'b11111;
    tail = 5'b00000;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_locked", 32'(locked), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(5'b11111, 5'b11111, 1'b1);
    check_eq("post_reset", 32'(last_grant), 32'(5'b00001));

    // Single requester
    for (int i = 0; i < 4; i++) begin
      drive_cycle(5'b00001, 5'b00001, 1'b1);
      check_eq("single", 32'(last_grant), 32'(5'b00001));
    end

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive_cycle(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
